// File: rtl/counter_defs.sv
// Shared constants and helpers for the Gray-count library blocks.
package counter_defs;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Number of bit positions in which two words differ.
  function automatic int unsigned hamming(input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    logic [31:0] d;
    n = 0;
    d = a ^ b;
    for (int unsigned i = 0; i < 32; i++) begin
      n += 32'(d[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter, the inverse of bin2gray.
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_sync_rx.sv
// Receive stage for a Gray count from another clock domain: synchronise,
// convert to binary, report movement. GRAY_SYNC_CHECK_EN adds the err_o checker.
module gray_sync_rx
  import counter_defs::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] step_o,
  output logic             changed_o,
  output logic             err_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gray_sync_rx: SYNC_STAGES must be 2..4");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  bin_next;

  // Only sync_q[0] sees the asynchronous input.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gray_i};
    end
  end

  assign gray_o = sync_q[SYNC_STAGES-1];

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray_i (gray_o),
    .bin_o  (bin_next)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bin_o     <= '0;
      step_o    <= '0;
      changed_o <= 1'b0;
    end else begin
      bin_o     <= bin_next;
      step_o    <= bin_next - bin_o;
      changed_o <= (bin_next != bin_o);
    end
  end

`ifdef GRAY_SYNC_CHECK_EN
  logic [WIDTH-1:0] gray_prev_q;
  logic             err_q;
  logic             violation;

  assign violation = hamming(32'(gray_o), 32'(gray_prev_q)) > 32'd1;

  // A new violation outranks a simultaneous clear.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      gray_prev_q <= '0;
      err_q       <= 1'b0;
    end else begin
      gray_prev_q <= gray_o;
      if (violation) begin
        err_q <= 1'b1;
      end else if (clear_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_rx.sv
// Self-checking bench for gray_sync_rx (WIDTH=5, SYNC_STAGES=2); honours GRAY_SYNC_CHECK_EN.
module tb_gray_sync_rx;

  localparam int unsigned W = 5;
  localparam int unsigned S = 2;
`ifdef GRAY_SYNC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic         clock_i = 1'b0;
  logic         reset_ni;
  logic [W-1:0] gray_i;
  logic         clear_i;
  logic [W-1:0] gray_o, bin_o, step_o;
  logic         changed_o, err_o;

  gray_sync_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clock_i   (clock_i),
    .reset_ni  (reset_ni),
    .gray_i    (gray_i),
    .clear_i   (clear_i),
    .gray_o    (gray_o),
    .bin_o     (bin_o),
    .step_o    (step_o),
    .changed_o (changed_o),
    .err_o     (err_o)
  );

  always #5 clock_i = ~clock_i;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: the synchroniser is a plain delay line, outputs follow arithmetic rules.
  int unsigned m_pipe[$];
  int unsigned m_gray, m_prev_gray, m_bin, m_step;
  bit          m_chg, m_err;

  function automatic int unsigned to_gray(input int unsigned b);
    return (b ^ (b >> 1)) % 32;
  endfunction

  function automatic int unsigned from_gray(input int unsigned g);
    for (int unsigned b = 0; b < 32; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int unsigned i = 0; i < S; i++) m_pipe.push_back(0);
    m_gray = 0; m_prev_gray = 0; m_bin = 0; m_step = 0; m_chg = 0; m_err = 0;
  endtask

  task automatic model_edge(input int unsigned g, input bit clr);
    int unsigned nb;
    nb     = from_gray(m_gray);
    m_step = (nb + 32 - m_bin) % 32;
    m_chg  = (nb != m_bin);
    m_bin  = nb;
    if (CHECK_EN) begin
      if ($countones(32'(m_gray ^ m_prev_gray)) > 1) m_err = 1;
      else if (clr) m_err = 0;
    end
    m_prev_gray = m_gray;
    m_pipe.push_back(g);
    void'(m_pipe.pop_front());
    m_gray = m_pipe[0];
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    check("gray_o", gray_o, m_gray);
    check("bin_o", bin_o, m_bin);
    check("step_o", step_o, m_step);
    check("changed_o", changed_o, m_chg);
    check("err_o", err_o, m_err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gray_o"}, gray_o, 0);
    check({tag, " bin_o"}, bin_o, 0);
    check({tag, " step_o"}, step_o, 0);
    check({tag, " changed_o"}, changed_o, 0);
    check({tag, " err_o"}, err_o, 0);
  endtask

  // Drive inputs, take one edge, advance the model, sample 1 time unit later.
  task automatic tick(input int unsigned g, input bit clr);
    gray_i  = W'(g);
    clear_i = clr;
    @(posedge clock_i);
    model_edge(g, clr);
    #1;
  endtask

  task automatic do_reset(input int unsigned g);
    gray_i   = W'(g);
    clear_i  = 1'b0;
    reset_ni = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    check_zero("reset");
    reset_ni = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int unsigned gray;
    int unsigned bin;
    int unsigned step;
    bit          chg;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int unsigned pulses, src, timeout;

    tbl[0] = '{6, 0, 0, 0};
    tbl[1] = '{6, 0, 0, 0};
    tbl[2] = '{6, 4, 4, 1};
    tbl[3] = '{6, 4, 0, 0};
    tbl[4] = '{13, 4, 0, 0};
    tbl[5] = '{13, 4, 0, 0};
    tbl[6] = '{13, 9, 5, 1};
    tbl[7] = '{13, 9, 0, 0};

    // Reset with a nonzero input, then a table of per-edge expectations.
    do_reset(6);
    for (int unsigned i = 0; i < 8; i++) begin
      tick(tbl[i].gray, 1'b0);
      check($sformatf("tbl%0d bin_o", i), bin_o, tbl[i].bin);
      check($sformatf("tbl%0d step_o", i), step_o, tbl[i].step);
      check($sformatf("tbl%0d changed_o", i), changed_o, tbl[i].chg);
    end

    // Hold 5'b01101 for 20 cycles.
    for (int unsigned i = 0; i < 20; i++) begin
      tick(13, 1'b0);
      check("hold bin_o", bin_o, 9);
      check("hold changed_o", changed_o, 0);
      check("hold step_o", step_o, 0);
    end

    // Full count sweep with wrap, one step every 4 cycles.
    do_reset(0);
    pulses = 0;
    for (int unsigned v = 1; v <= 32; v++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        tick(to_gray(v % 32), 1'b0);
        check_model();
        if (changed_o) begin
          pulses++;
          check("sweep step_o", step_o, 1);
        end
      end
    end
    repeat (4) begin
      tick(0, 1'b0);
      if (changed_o) pulses++;
    end
    check("sweep pulses", pulses, 32);

    // Two-bit jump 00000 -> 00011, then clear.
    do_reset(0);
    tick(0, 1'b0);
    tick(0, 1'b0);
    tick(3, 1'b0);
    tick(3, 1'b0);
    tick(3, 1'b0);
    check("jump bin_o", bin_o, 2);
    check("jump step_o", step_o, 2);
    check("jump changed_o", changed_o, 1);
    check("jump err_o", err_o, CHECK_EN ? 1 : 0);
    for (int unsigned i = 0; i < 3; i++) begin
      tick(3, 1'b0);
      check("jump err_o held", err_o, CHECK_EN ? 1 : 0);
      check_model();
    end
    tick(3, 1'b1);
    check("clear err_o", err_o, 0);
    check_model();

    // Asynchronous reset mid-cycle while bin_o = 17.
    do_reset(0);
    timeout = 0;
    while (bin_o != 17 && timeout < 20) begin
      tick(to_gray(17), 1'b0);
      timeout++;
    end
    check("pre-reset bin_o", bin_o, 17);
    #2;
    reset_ni = 1'b0;
    #1;
    check_zero("async");
    @(posedge clock_i);
    #1;
    reset_ni = 1'b1;
    model_reset();

    // Random walk: mostly single steps, occasional jumps and clears.
    src = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r < 6) src = (src + 1) % 32;
      else if (r == 15) src = $urandom_range(0, 31);
      tick(to_gray(src), ($urandom_range(0, 7) == 0));
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gray_sync_rx.md
Name: gray_sync_rx

Overview:
Receive-side stage for Gray-coded counts produced by bin2gray in another clock domain, e.g. FIFO pointers and frame/line counters crossing into the pixel clock.
- Synchronises the Gray word through a flop chain, converts it back to binary and registers it.
- Reports whether the count moved since the previous sample, and by how much.
- Consumers (FIFO full/empty logic, timing generators) read only this block's registered outputs.

Parameters:
WIDTH, 5, width of the Gray/binary count.
SYNC_STAGES, 2, synchroniser flop depth; legal values 2..4.

Ports:
clock_i  input  1  destination-domain clock, rising edge.
reset_ni  input  1  asynchronous active-low reset; all state cleared while low.
gray_i  input  WIDTH  Gray count from the source domain (asynchronous to clock_i).
clear_i  input  1  synchronous clear of the sticky err_o flag.
gray_o  output  WIDTH  last synchroniser stage (Gray).
bin_o  output  WIDTH  registered binary equivalent of gray_o.
step_o  output  WIDTH  registered modular difference between the new bin_o and the previous bin_o.
changed_o  output  1  one-cycle pulse, registered, when bin_o takes a new value.
err_o  output  1  sticky Gray-step violation flag (optional feature only).

Behaviour:
- Reset (reset_ni low, asynchronous assert, release synchronous to the next rising edge):
  - All synchroniser stages, bin_o, step_o, changed_o and err_o are 0.
  - The internal previous-value register is 0.
- Synchroniser: stage[0] <= gray_i; stage[k] <= stage[k-1]. gray_o = stage[SYNC_STAGES-1].
- Conversion: binary is combinational gray2bin of gray_o (b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]).
- Registers: bin_o <= gray2bin(gray_o), updated every cycle.
- Latency:
  - A gray_i change that is stable before edge 1 appears on gray_o after edge SYNC_STAGES.
  - It appears on bin_o, step_o and changed_o after edge SYNC_STAGES+1, i.e. 3 edges for the default.
- Difference: step_o <= (gray2bin(gray_o) - bin_o) mod 2^WIDTH, evaluated each cycle.
  - Wrap-around is native; 31 -> 0 gives step_o = 1 for WIDTH = 5.
  - step_o = 0 when there is no change.
- changed_o <= (gray2bin(gray_o) != bin_o). It is high for exactly one cycle per distinct new value.
- First cycle after reset: if gray_i is already nonzero, the first converted value is compared against bin_o = 0, so changed_o pulses and step_o equals that value. This is intended.
- Metastability: only stage[0] samples the asynchronous input. No other logic reads gray_i or stage[0].
- Reset asserted mid-operation clears everything immediately, including a pending changed_o pulse.

Optional Feature:
Macro GRAY_SYNC_CHECK_EN.
- Defined:
  - Each cycle, if gray_o differs from its previous-cycle value in more than one bit, err_o is set.
  - err_o stays high until clear_i is sampled high or reset.
  - If clear_i and a new violation occur in the same cycle, set wins.
  - Valid only when the source advances at most one step per destination cycle.
- Undefined: err_o is a constant 0; clear_i is ignored; no checking logic is built.

Decomposition:
- Shared package/header counter_defs:
  - SYNC_STAGES_MIN = 2 and SYNC_STAGES_MAX = 4 constants.
  - Popcount/Hamming helper function used by the check.
- Sub-module gray2bin (WIDTH parameter, gray_i -> bin_o, purely combinational). It mirrors bin2gray and is reused by other counter-library blocks.

Test Plan:
1. WIDTH = 5, hold reset_ni low with gray_i = 5'b00110 -> all outputs 0. Release -> after 3 edges bin_o = 4, step_o = 4, changed_o pulses for 1 cycle.
2. Source binary 0..31 through bin2gray, one step every 4 cycles -> bin_o tracks with 3-cycle latency, step_o = 1 on each change, 32 changed_o pulses including the 31 -> 0 wrap.
3. Hold gray_i = 5'b01101 for 20 cycles -> bin_o = 9, changed_o = 0, step_o = 0 after the first update.
4. With GRAY_SYNC_CHECK_EN, jump gray_i 5'b00000 -> 5'b00011 -> bin_o = 2, step_o = 2, err_o = 1 and held. Pulse clear_i -> err_o = 0 next cycle.
5. Drop reset_ni at mid-cycle (#3 after an edge) while bin_o = 17 -> all outputs 0 before the next edge.
6. Without GRAY_SYNC_CHECK_EN, repeat scenario 4 -> err_o stays 0 and bin_o/step_o are unchanged from scenario 4.
